call_stack: RTL and testbench

//  Hardware return-address stack serving the controller's push/pop/StackSel outputs.
//  - Subroutine call (push): stores the return address.
//  - Return (pop): supplies the return address to the PC mux.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/call_stack_mem.sv | 31 +++
 rtl/call_stack.sv | 136 +++++++++++++
 tb/tb_call_stack.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/instruction widths, controller opcodes and the
// return-address stack's per-cycle action encoding.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  localparam logic [4:0]         OP_CALL   = 5'b11101;
  localparam logic [5:0]         OP_RETURN = 6'b111100;
  localparam logic [4:0]         OP_JUMP   = 5'b11100;
  localparam logic [INSTR_W-1:0] OP_HALT   = '1;

  typedef enum logic [1:0] {
    STK_HOLD = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2,
    STK_TAIL = 2'd3
  } stack_op_e;

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x ADDR_W register array for the return-address stack: one clocked write
// port, one combinational read port, cleared by asynchronous reset.
module call_stack_mem #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // NOTE: this array is small and flop-based, so resetting every entry is cheap
  // and makes a reset discard all stored return addresses at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack (circular array indexed by base+depth).
// Build option: define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module call_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              halt,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W:0]    depth,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   DEPTH_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DEPTH_MAX = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  base_q, base_d;
  logic [PTR_W:0]    depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              is_empty, is_full;
  logic [PTR_W-1:0]  top_idx, free_idx;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  stack_op_e         op;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);
  // When full the low pointer bits of depth are zero, so free_idx lands on the oldest entry.
  assign free_idx = base_q + depth_q[PTR_W-1:0];
  assign top_idx  = free_idx - PTR_ONE;

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of inferred latches.
    op = STK_HOLD;
    if (!halt) begin
      unique case ({push, pop})
        2'b10:   op = STK_PUSH;
        2'b01:   op = STK_POP;
        2'b11:   op = STK_TAIL;
        default: op = STK_HOLD;
      endcase
    end
  end

  always_comb begin
    base_d  = base_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = free_idx;
    unique case (op)
      STK_PUSH: begin
        if (!is_full) begin
          we      = 1'b1;
          depth_d = depth_q + DEPTH_ONE;
        end else begin
          ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          we     = 1'b1;
          base_d = base_q + PTR_ONE;
`endif
        end
      end
      STK_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          depth_d = depth_q - DEPTH_ONE;
        end
      end
      STK_TAIL: begin
        we = 1'b1;
        if (is_empty) begin
          depth_d = DEPTH_ONE;
          unf_d   = 1'b1;
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  call_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_addr),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  assign top_addr  = is_empty ? '0 : rdata;
  assign depth     = depth_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: expected states are queued as each step is
// driven and popped/compared against the outputs once the step has taken effect.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, halt;
  logic [11:0] push_addr;
  logic [11:0] top_addr;
  logic [3:0]  depth;
  logic        empty, full, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [11:0] top;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];

  call_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .halt      (halt),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [11:0] top, input logic [3:0] dep,
                              input logic ovf, input logic unf);
    exp_t e;
    e.tag   = tag;
    e.top   = top;
    e.depth = dep;
    e.empty = (dep == 4'd0);
    e.full  = (dep == 4'd8);
    e.ovf   = ovf;
    e.unf   = unf;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      cmp({e.tag, ".top"},   32'(top_addr),  32'(e.top));
      cmp({e.tag, ".depth"}, 32'(depth),     32'(e.depth));
      cmp({e.tag, ".empty"}, 32'(empty),     32'(e.empty));
      cmp({e.tag, ".full"},  32'(full),      32'(e.full));
      cmp({e.tag, ".ovf"},   32'(overflow),  32'(e.ovf));
      cmp({e.tag, ".unf"},   32'(underflow), 32'(e.unf));
    end
  endtask

  // Drive one request for one clock, then compare the state one cycle later.
  task automatic step(input string tag, input logic p, input logic q, input logic h,
                      input logic [11:0] a, input logic [11:0] top, input logic [3:0] dep,
                      input logic ovf, input logic unf);
    push      = p;
    pop       = q;
    halt      = h;
    push_addr = a;
    expect_state(tag, top, dep, ovf, unf);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    halt = 1'b0;
    check_sb();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    halt      = 1'b0;
    push_addr = '0;

    // 1. reset state
    #3;
    expect_state("t1_reset", 12'h000, 4'd0, 1'b0, 1'b0);
    check_sb();
    #7 rst = 1'b0;
    @(posedge clk);
    #1;

    // 2. three pushes, one pop, drain
    step("t2_push10", 1, 0, 0, 12'h010, 12'h010, 4'd1, 0, 0);
    step("t2_push20", 1, 0, 0, 12'h020, 12'h020, 4'd2, 0, 0);
    step("t2_push30", 1, 0, 0, 12'h030, 12'h030, 4'd3, 0, 0);
    step("t2_pop",    0, 1, 0, 12'h000, 12'h020, 4'd2, 0, 0);
    step("t2_pop2",   0, 1, 0, 12'h000, 12'h010, 4'd1, 0, 0);
    step("t2_pop3",   0, 1, 0, 12'h000, 12'h000, 4'd0, 0, 0);

    // 3. fill to DEPTH, then push while full
    for (int i = 1; i <= 8; i++) begin
      step($sformatf("t3_fill%0d", i), 1, 0, 0, 12'(i), 12'(i), 4'(i), 0, 0);
    end
`ifdef CALL_STACK_WRAP_EN
    step("t3_push_full", 1, 0, 0, 12'h0FF, 12'h0FF, 4'd8, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("t3_pop%0d", k), 0, 1, 0, 12'h000,
           (k < 8) ? 12'(9 - k) : 12'h000, 4'(8 - k), 1, 0);
    end
`else
    step("t3_push_full", 1, 0, 0, 12'h0FF, 12'h008, 4'd8, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("t3_pop%0d", k), 0, 1, 0, 12'h000,
           (k < 8) ? 12'(8 - k) : 12'h000, 4'(8 - k), 1, 0);
    end
`endif

    // 4. pop on empty, then a valid push/pop pair keeps underflow sticky
    step("t4_pop_empty", 0, 1, 0, 12'h000, 12'h000, 4'd0, 1, 1);
    step("t4_push",      1, 0, 0, 12'h100, 12'h100, 4'd1, 1, 1);
    step("t4_pop",       0, 1, 0, 12'h000, 12'h000, 4'd0, 1, 1);

    // 5. tail-call replaces the top; push&pop on empty acts as a push
    step("t5_push11", 1, 0, 0, 12'h011, 12'h011, 4'd1, 1, 1);
    step("t5_push22", 1, 0, 0, 12'h022, 12'h022, 4'd2, 1, 1);
    step("t5_tail55", 1, 1, 0, 12'h055, 12'h055, 4'd2, 1, 1);
    step("t5_pop",    0, 1, 0, 12'h000, 12'h011, 4'd1, 1, 1);
    step("t5_pop2",   0, 1, 0, 12'h000, 12'h000, 4'd0, 1, 1);
    step("t5_tail_empty", 1, 1, 0, 12'h066, 12'h066, 4'd1, 1, 1);

    // 6. halt freezes everything; asynchronous reset clears between edges
    step("t6_halt_push", 1, 0, 1, 12'h077, 12'h066, 4'd1, 1, 1);
    step("t6_halt_pop",  0, 1, 1, 12'h000, 12'h066, 4'd1, 1, 1);
    #3 rst = 1'b1;
    #1;
    expect_state("t6_async_rst", 12'h000, 4'd0, 1'b0, 1'b0);
    check_sb();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step("t6_push_after_rst", 1, 0, 0, 12'h044, 12'h044, 4'd1, 0, 0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
